// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequencing FSM for the multi-cycle RV32I-subset core. It walks each
//   instruction through fetch / decode / execute / memory / writeback over a
//   shared memory port. It waits on the memory ready handshake. Illegal
//   encodings and memory timeouts send it to an absorbing FAULT state.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   opcode_i, funct3_i    IR fields, stable from DECODE onward
//   br_taken_i            datapath compare result for branch_type_o
//   mem_ready_i           memory finishes the current access this cycle
//   pc_write_o/pc_src_o   PC load enable / PC source select
//   ir_write_o            IR/oldPC load enable
//   iord_o                memory address select (0 = PC, 1 = ALU)
//   mem_read_o/mem_write_o memory strobes
//   reg_write_o/mem_to_reg_o register write enable / writeback source
//   alu_src_b_o/alu_op_o  ALU operand-B select / ALU operation class
//   branch_type_o         beq/bne/blt/bge select for the comparator
//   state_o               current state, for debug
//   illegal_o, timeout_o  sticky fault flags
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       br_taken_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] branch_type_o,
    output logic [3:0] state_o,
    output logic       illegal_o,
    output logic       timeout_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        ALU_WB  = 4'd4,
        ADDR    = 4'd5,
        MEM_RD  = 4'd6,
        LOAD_WB = 4'd7,
        MEM_WR  = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10,
        FAULT   = 4'd15
    } state_t;

    // Moore control word, registered alongside the state.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] branch_type;
    } ctl_t;

    state_t           state, nxt;
    ctl_t             ctl_q;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q, timeout_q;
    logic             set_ill, set_to, wait_st, to_hit;

    // Control word for a given state. IR fields are stable from DECODE on,
    // so sampling them on the edge into BRANCH/JUMP is safe.
    function automatic ctl_t ctl_of(input state_t s, input logic [6:0] op,
                                    input logic [2:0] f3);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:   c.mem_read = 1'b1;
            EXEC_R:  c.alu_op = 2'b10;
            EXEC_I:  begin c.alu_op = 2'b11; c.alu_src_b = 1'b1; end
            ALU_WB:  c.reg_write = 1'b1;
            ADDR:    c.alu_src_b = 1'b1;
            MEM_RD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            LOAD_WB: begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
            MEM_WR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            BRANCH: begin
                c.alu_op      = 2'b01;
                c.pc_src      = 2'b01;
                // 000/001/100/101 -> 00/01/10/11
                c.branch_type = {f3[2], f3[0]};
            end
            JUMP: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b10;
                c.pc_write   = 1'b1;
                c.pc_src     = (op == OP_JALR) ? 2'b10 : 2'b01;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic.
    always_comb begin
        nxt     = state;
        set_ill = 1'b0;
        set_to  = 1'b0;
        wait_st = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
        to_hit  = (MEM_TIMEOUT > 0) && wait_st && !mem_ready_i &&
                  (cnt == CNT_W'(MEM_TIMEOUT));
        case (state)
            FETCH:  if (mem_ready_i) nxt = DECODE;
            DECODE: begin
                case (opcode_i)
                    OP_R:              nxt = EXEC_R;
                    OP_I:              nxt = EXEC_I;
                    OP_LOAD, OP_STORE: nxt = ADDR;
                    OP_BR: begin
                        if (funct3_i == 3'b000 || funct3_i == 3'b001 ||
                            funct3_i == 3'b100 || funct3_i == 3'b101)
                            nxt = BRANCH;
                        else
                            nxt = FAULT;
                    end
                    OP_JAL, OP_JALR:   nxt = ENABLE_JUMP ? JUMP : FAULT;
                    default:           nxt = FAULT;
                endcase
                set_ill = (nxt == FAULT);
            end
            EXEC_R, EXEC_I: nxt = ALU_WB;
            ALU_WB:  nxt = FETCH;
            ADDR:    nxt = (opcode_i == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:  if (mem_ready_i) nxt = LOAD_WB;
            LOAD_WB: nxt = FETCH;
            MEM_WR:  if (mem_ready_i) nxt = FETCH;
            BRANCH:  nxt = FETCH;
            JUMP:    nxt = FETCH;
            default: nxt = FAULT;
        endcase
        // Only reachable with ready low, so a same-cycle ready always wins.
        if (to_hit) begin
            nxt    = FAULT;
            set_to = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= FETCH;
            ctl_q     <= ctl_of(FETCH, 7'd0, 3'd0);
            cnt       <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= nxt;
            ctl_q     <= ctl_of(nxt, opcode_i, funct3_i);
            illegal_q <= illegal_q | set_ill;
            timeout_q <= timeout_q | set_to;
            // Any state change (entry to a wait state included) restarts the
            // count; self-loops in a wait state count stalled cycles.
            if (nxt != state)
                cnt <= '0;
            else if (wait_st && !mem_ready_i)
                cnt <= cnt + 1'b1;
        end
    end

    // Strobes are gated by rst_i so nothing writes while reset is held,
    // including the FETCH Mealy path, which would otherwise follow
    // mem_ready_i during reset.
    logic fetch_go;
    assign fetch_go = rst_i && (state == FETCH) && mem_ready_i;

    assign ir_write_o    = fetch_go;
    assign pc_write_o    = fetch_go ||
                           (rst_i && (ctl_q.pc_write ||
                                      ((state == BRANCH) && br_taken_i)));
    assign pc_src_o      = ctl_q.pc_src;
    assign iord_o        = ctl_q.iord;
    assign mem_read_o    = rst_i && ctl_q.mem_read;
    assign mem_write_o   = rst_i && ctl_q.mem_write;
    assign reg_write_o   = rst_i && ctl_q.reg_write;
    assign mem_to_reg_o  = ctl_q.mem_to_reg;
    assign alu_src_b_o   = ctl_q.alu_src_b;
    assign alu_op_o      = ctl_q.alu_op;
    assign branch_type_o = ctl_q.branch_type;
    assign state_o       = state;
    assign illegal_o     = illegal_q;
    assign timeout_o     = timeout_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I-subset core. It replaces single-cycle decoding with a sequenced state machine that drives a shared-memory datapath. It waits on a memory ready handshake and detects illegal encodings and memory timeouts. It sits between the instruction register (opcode/funct3), the ALU compare flag, the unified memory port and all datapath write enables and muxes.

## Interface
Parameters:
- MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready_i before faulting; 0 disables the timeout.
- ENABLE_JUMP, 1, 1 = jal/jalr supported; 0 = jal/jalr decode as illegal.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- opcode_i  in  7  IR[6:0], valid from DECODE onward
- funct3_i  in  3  IR[14:12]
- br_taken_i  in  1  datapath comparison result for the current branch_type_o
- mem_ready_i  in  1  memory completes the current access this cycle
- pc_write_o  out  1  PC load enable
- pc_src_o  out  2  00 = PC+4, 01 = PC-relative target (oldPC+imm), 10 = jalr target ((rs1+imm)&~1)
- ir_write_o  out  1  IR/oldPC load enable
- iord_o  out  1  memory address select: 0 = PC, 1 = ALU result
- mem_read_o, mem_write_o  out  1 each  memory strobes
- reg_write_o  out  1  register-file write enable
- mem_to_reg_o  out  2  00 = ALU, 01 = memory data, 10 = PC (PC+4 of the current instruction)
- alu_src_b_o  out  1  0 = rs2, 1 = immediate
- alu_op_o  out  2  00 = add, 01 = compare/branch, 10 = R-type funct, 11 = I-type funct
- branch_type_o  out  2  00 = beq, 01 = bne, 10 = blt, 11 = bge
- state_o  out  4  current state encoding, for debug
- illegal_o, timeout_o  out  1 each  sticky fault flags

## Operation
State encodings:
- FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, ALU_WB = 4, ADDR = 5, MEM_RD = 6, LOAD_WB = 7, MEM_WR = 8, BRANCH = 9, JUMP = 10, FAULT = 15.

Output types:
- Outputs are Moore from state, except two Mealy outputs: FETCH ir_write_o/pc_write_o (which follow mem_ready_i) and BRANCH pc_write_o (which follows br_taken_i).
- Unlisted strobes are 0. Unlisted mux selects are 00 or 0.

Per-state behaviour:
- FETCH: mem_read_o = 1, iord_o = 0. When mem_ready_i = 1: ir_write_o = 1, pc_write_o = 1, pc_src_o = 00, next state is DECODE. Otherwise stay in FETCH.
- DECODE: no strobes. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → ADDR
  - 1100011 → BRANCH, only when funct3 ∈ {000, 001, 100, 101}
  - 1101111 or 1100111 → JUMP, only when ENABLE_JUMP = 1
  - anything else → FAULT, and set illegal_o.
- EXEC_R: alu_op_o = 10. Next state is ALU_WB.
- EXEC_I: alu_op_o = 11, alu_src_b_o = 1. Next state is ALU_WB.
- ALU_WB: reg_write_o = 1, mem_to_reg_o = 00. Next state is FETCH.
- ADDR: alu_op_o = 00, alu_src_b_o = 1. Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read_o = 1, iord_o = 1. Wait for mem_ready_i, then go to LOAD_WB.
- LOAD_WB: reg_write_o = 1, mem_to_reg_o = 01. Next state is FETCH.
- MEM_WR: mem_write_o = 1, iord_o = 1. Wait for mem_ready_i, then go to FETCH.
- BRANCH: alu_op_o = 01, branch_type_o from funct3 (000→00, 001→01, 100→10, 101→11). pc_write_o = br_taken_i, pc_src_o = 01. Next state is FETCH.
- JUMP: reg_write_o = 1, mem_to_reg_o = 10, pc_write_o = 1. pc_src_o = 10 for jalr, 01 for jal. Next state is FETCH.
- FAULT: all strobes 0. FAULT is absorbing until reset.

Timeout counter:
- Width is $clog2(MEM_TIMEOUT+1), minimum 1 bit.
- Cleared on every entry to FETCH, MEM_RD or MEM_WR.
- Increments each cycle in a wait state while mem_ready_i = 0.
- When it equals MEM_TIMEOUT (MEM_TIMEOUT > 0) with mem_ready_i still 0, next state is FAULT and timeout_o is set.
- mem_ready_i = 1 on the same cycle wins over the timeout.

Flags:
- illegal_o and timeout_o are registered. Once set, they stay set until reset.

## Timing
- Reset: while rst_i = 0, state is FETCH, the counter is 0, the flags are 0, and every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0. Fetch begins on the first edge after deassertion.
- Reset mid-instruction aborts it immediately. No partial write enable may be asserted after rst_i falls.
- Zero-wait latency per instruction:
  - R-type and I-type ALU: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch and jump: 3 cycles
- Each wait cycle on mem_ready_i adds 1 cycle.
- ir_write_o and pc_write_o in FETCH assert in the same cycle as mem_ready_i, never earlier.

## Test plan
- Reset then R-type (opcode 0110011) with mem_ready_i = 1 → state sequence 0,1,2,4,0. reg_write_o = 1 only in state 4.
- Load with 2 wait cycles in MEM_RD → sequence 0,1,5,6,6,6,7,0. mem_read_o and iord_o = 1 throughout state 6.
- bne (funct3 001): br_taken_i = 1 → pc_write_o = 1, pc_src_o = 01, branch_type_o = 01. Repeat with br_taken_i = 0 → pc_write_o = 0. Both cases take 3 cycles.
- jalr with ENABLE_JUMP = 1 → JUMP with pc_src_o = 10, mem_to_reg_o = 10. Same with ENABLE_JUMP = 0 → FAULT, illegal_o = 1, and it stays there over 20 cycles.
- MEM_TIMEOUT = 3, mem_ready_i held 0 in FETCH → FAULT after 4 FETCH cycles with timeout_o = 1. mem_ready_i = 1 on the 4th cycle → DECODE instead, no fault.
- Assert rst_i = 0 during LOAD_WB → reg_write_o drops to 0 immediately. After release: state 0 and flags 0.
